// File: rtl/ppu_pkg.sv
//------------------------------------------------------------------------------
// Module      : ppu_pkg
// Description : Shared types, defaults and the palette mirror function.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ppu_pkg;

  localparam int unsigned COLOR_W_DEF  = 6;
  localparam int unsigned PAL_BITS_DEF = 2;
  localparam int unsigned IDX_BITS_DEF = 2;
  localparam logic [5:0]  GRAY_MASK_DEF = 6'h30;

  // PPUMASK register bit positions
  localparam int unsigned PPUMASK_GRAY_BIT = 0;
  localparam int unsigned PPUMASK_EMPH_LSB = 5;

  typedef struct packed {
    logic                    sprite;
    logic [PAL_BITS_DEF-1:0] palette;
    logic [IDX_BITS_DEF-1:0] index;
  } pixel_info_t;

  // Index 0 of every sprite palette aliases onto the matching background entry.
  function automatic logic [7:0] mir(input logic [7:0] a,
                                     input int unsigned idx_bits,
                                     input int unsigned addr_w);
    logic [7:0] idx_mask;
    logic [7:0] res;
    idx_mask = 8'((9'd1 << idx_bits) - 9'd1);
    res      = a;
    if ((a & idx_mask) == 8'd0) begin
      res = a & ~(8'd1 << (addr_w - 1));
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/palette_ram.sv
//------------------------------------------------------------------------------
// Module      : palette_ram
// Description : Palette register file, one write port, two async read ports.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module palette_ram #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned COLOR_W = 6,
  parameter int unsigned DEPTH   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  craddr,
  output logic [COLOR_W-1:0] crdata,
  input  logic [ADDR_W-1:0]  praddr,
  output logic [COLOR_W-1:0] prdata
);

  logic [COLOR_W-1:0] mem_q [DEPTH];
  logic [COLOR_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign crdata = mem_q[craddr];
  assign prdata = mem_q[praddr];

endmodule

`default_nettype wire

// File: rtl/palette_lut.sv
//------------------------------------------------------------------------------
// Module      : palette_lut
// Description : CPU palette access plus 2-stage pixel colour lookup.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module palette_lut
  import ppu_pkg::*;
#(
  parameter  int unsigned        COLOR_W   = COLOR_W_DEF,
  parameter  int unsigned        PAL_BITS  = PAL_BITS_DEF,
  parameter  int unsigned        IDX_BITS  = IDX_BITS_DEF,
  parameter  logic [COLOR_W-1:0] GRAY_MASK = COLOR_W'(GRAY_MASK_DEF),
  localparam int unsigned        ADDR_W    = 1 + PAL_BITS + IDX_BITS,
  localparam int unsigned        DEPTH     = 2 ** ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [7:0]         wdata,
  input  logic               write,
  input  logic               read,
  output logic [7:0]         rdata,
  input  logic               grayscale,
  input  logic [2:0]         emphasis,
  input  logic               override_en,
  input  logic [ADDR_W-1:0]  override_addr,
  input  logic               pix_valid_in,
  input  logic [ADDR_W-1:0]  pixel_info,
  output logic               pix_valid_out,
  output logic [COLOR_W-1:0] pixel_color,
  output logic [2:0]         pixel_emph
);

  logic [ADDR_W-1:0]  cpu_addr;
  logic [ADDR_W-1:0]  ra;
  logic [COLOR_W-1:0] cpu_color;
  logic [COLOR_W-1:0] pix_color;
  logic [COLOR_W-1:0] gray_and;
  logic               unused_wdata;

  logic [7:0]         rdata_q, rdata_d;
  logic               s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
  logic [2:0]         s1_emph_q, s1_emph_d;
  logic               out_valid_q, out_valid_d;
  logic [COLOR_W-1:0] out_color_q, out_color_d;
  logic [2:0]         out_emph_q, out_emph_d;

  assign cpu_addr     = ADDR_W'(mir(8'(addr), IDX_BITS, ADDR_W));
  assign gray_and     = grayscale ? GRAY_MASK : '1;
  assign unused_wdata = ^wdata[7:COLOR_W];

  palette_ram #(
    .ADDR_W  (ADDR_W),
    .COLOR_W (COLOR_W),
    .DEPTH   (DEPTH)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we     (write),
    .waddr  (cpu_addr),
    .wdata  (wdata[COLOR_W-1:0]),
    .craddr (cpu_addr),
    .crdata (cpu_color),
    .praddr (s1_addr_q),
    .prdata (pix_color)
  );

  // Transparent pixels collapse onto the universal backdrop at entry 0.
  always_comb begin
    ra = pixel_info;
    if (override_en) begin
      ra = ADDR_W'(mir(8'(override_addr), IDX_BITS, ADDR_W));
    end else if (pixel_info[IDX_BITS-1:0] == '0) begin
      ra = '0;
    end
  end

  always_comb begin
    rdata_d     = read ? 8'(cpu_color & gray_and) : rdata_q;
    s1_valid_d  = pix_valid_in;
    s1_addr_d   = ra;
    s1_emph_d   = emphasis;
    out_valid_d = s1_valid_q;
    out_color_d = pix_color & gray_and;
    out_emph_d  = s1_emph_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_emph_q   <= '0;
      out_valid_q <= 1'b0;
      out_color_q <= '0;
      out_emph_q  <= '0;
    end else begin
      rdata_q     <= rdata_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_emph_q   <= s1_emph_d;
      out_valid_q <= out_valid_d;
      out_color_q <= out_color_d;
      out_emph_q  <= out_emph_d;
    end
  end

  assign rdata         = rdata_q;
  assign pix_valid_out = out_valid_q;
  assign pixel_color   = out_color_q;
  assign pixel_emph    = out_emph_q;

endmodule

`default_nettype wire

// File: tb/tb_palette_lut.sv
//------------------------------------------------------------------------------
// Module      : tb_palette_lut
// Description : Randomised scoreboard bench for palette_lut.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_palette_lut;
  import ppu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       write;
  logic       read;
  logic [7:0] rdata;
  logic       grayscale;
  logic [2:0] emphasis;
  logic       override_en;
  logic [4:0] override_addr;
  logic       pix_valid_in;
  logic [4:0] pixel_info;
  logic       pix_valid_out;
  logic [5:0] pixel_color;
  logic [2:0] pixel_emph;

  palette_lut dut (
    .clk           (clk),
    .reset         (reset),
    .addr          (addr),
    .wdata         (wdata),
    .write         (write),
    .read          (read),
    .rdata         (rdata),
    .grayscale     (grayscale),
    .emphasis      (emphasis),
    .override_en   (override_en),
    .override_addr (override_addr),
    .pix_valid_in  (pix_valid_in),
    .pixel_info    (pixel_info),
    .pix_valid_out (pix_valid_out),
    .pixel_color   (pixel_color),
    .pixel_emph    (pixel_emph)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [5:0] color;
    logic [2:0] emph;
  } pix_exp_t;

  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_exp_t;

  pix_exp_t   pq[$];
  rd_exp_t    rq[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic       checking = 1'b0;

  // Reference state: palette contents and the pixel currently in flight.
  logic [5:0] ent [32];
  logic       s1_pend;
  int         s1_ra;
  logic [2:0] s1_emph;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tb_mir(input int a);
    return (a % 4 == 0) ? a % 16 : a;
  endfunction

  function automatic logic [5:0] gmask(input logic [5:0] c);
    return grayscale ? (c & 6'h30) : c;
  endfunction

  function automatic int tb_ra();
    if (override_en) return tb_mir(int'(override_addr));
    if (pixel_info % 4 == 0) return 0;
    return int'(pixel_info);
  endfunction

  task automatic step();
    pix_exp_t pe;
    rd_exp_t  re;
    if (reset) begin
      for (int i = 0; i < 32; i++) ent[i] = 6'd0;
      s1_pend = 1'b0;
    end else begin
      if (s1_pend) begin
        pe.due   = cyc + 1;
        pe.color = gmask(ent[s1_ra]);
        pe.emph  = s1_emph;
        pq.push_back(pe);
      end
      s1_pend = pix_valid_in;
      s1_ra   = tb_ra();
      s1_emph = emphasis;
      if (read) begin
        re.due  = cyc + 1;
        re.data = {2'b00, gmask(ent[tb_mir(int'(addr))])};
        rq.push_back(re);
      end
      if (write) ent[tb_mir(int'(addr))] = wdata[5:0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; write = 1'b0; read = 1'b0; pix_valid_in = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    idle(); addr = a; wdata = d; write = 1'b1; step(); idle();
  endtask

  task automatic do_read(input logic [4:0] a);
    idle(); addr = a; read = 1'b1; step(); idle();
  endtask

  task automatic do_pix(input logic [4:0] p);
    idle(); pixel_info = p; pix_valid_in = 1'b1; step(); idle();
  endtask

  always @(negedge clk) begin
    logic     exp_v;
    pix_exp_t pe;
    rd_exp_t  re;
    if (checking) begin
      exp_v = (pq.size() > 0) && (pq[0].due == cyc);
      n_cmp++;
      if (pix_valid_out !== exp_v) begin
        n_fail++;
        $display("FAIL pix_valid_out cyc=%0d got=%b exp=%b", cyc, pix_valid_out, exp_v);
      end
      if (exp_v) begin
        pe = pq.pop_front();
        n_cmp++;
        if (pixel_color !== pe.color || pixel_emph !== pe.emph) begin
          n_fail++;
          $display("FAIL pixel cyc=%0d got color=%h emph=%b exp color=%h emph=%b",
                   cyc, pixel_color, pixel_emph, pe.color, pe.emph);
        end
      end
      while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
      if (rq.size() > 0 && rq[0].due == cyc) begin
        re = rq.pop_front();
        n_cmp++;
        if (rdata !== re.data) begin
          n_fail++;
          $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, re.data);
        end
      end
    end
  end

  initial begin
    pixel_info_t pi;
    logic [7:0]  ppumask;

    idle();
    addr = '0; wdata = '0; grayscale = 1'b0; emphasis = '0;
    override_en = 1'b0; override_addr = '0; pixel_info = '0;
    s1_pend = 1'b0; s1_ra = 0; s1_emph = '0;
    for (int i = 0; i < 32; i++) ent[i] = 6'd0;

    reset = 1'b1;
    step();
    checking = 1'b1;
    step();
    idle();

    for (int a = 0; a < 32; a++) do_read(5'(a));

    do_write(5'h10, 8'h2A);
    do_read(5'h00);
    do_read(5'h10);
    do_write(5'h11, 8'h05);
    do_read(5'h01);

    do_write(5'h06, 8'h16);
    do_pix(5'h06);
    step(); step(); step();
    do_pix(5'h04);
    step(); step();

    grayscale = 1'b1; emphasis = 3'b101;
    do_pix(5'h06);
    do_read(5'h06);
    step(); step();
    grayscale = 1'b0; emphasis = 3'b000;

    do_write(5'h04, 8'h21);
    override_en = 1'b1; override_addr = 5'h14;
    for (int i = 0; i < 4; i++) do_pix(5'h1F);
    step(); step();
    override_en = 1'b0;

    do_write(5'h07, 8'h11);
    for (int i = 0; i < 4; i++) begin
      idle();
      pixel_info = 5'h07; pix_valid_in = 1'b1;
      reset = (i == 1);
      step();
    end
    idle();
    for (int a = 0; a < 32; a++) do_read(5'(a));

    do_pix(5'h00);
    idle(); pixel_info = 5'h00; pix_valid_in = 1'b1;
    addr = 5'h00; wdata = 8'h3F; write = 1'b1;
    step();
    idle();
    step(); step(); step();

    for (int n = 0; n < 800; n++) begin
      ppumask       = 8'($urandom);
      reset         = ($urandom_range(0, 99) == 0);
      write         = ($urandom_range(0, 4) == 0);
      read          = ($urandom_range(0, 9) < 3);
      addr          = 5'($urandom_range(0, 31));
      wdata         = 8'($urandom);
      grayscale     = ($urandom_range(0, 3) == 0) ? ppumask[PPUMASK_GRAY_BIT] : 1'b0;
      emphasis      = ppumask[PPUMASK_EMPH_LSB +: 3];
      override_en   = ($urandom_range(0, 9) == 0);
      override_addr = 5'($urandom_range(0, 31));
      pi            = pixel_info_t'(5'($urandom_range(0, 31)));
      pixel_info    = pi;
      pix_valid_in  = ($urandom_range(0, 9) < 7);
      step();
    end

    idle();
    for (int i = 0; i < 4; i++) step();

    n_cmp++;
    if (pq.size() != 0 || rq.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending_pix=%0d pending_rd=%0d exp=0", pq.size(), rq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
